// File: rtl/gate_lab_pkg.sv
// Shared constants and helpers for the gate-lab input conditioning blocks.
package gate_lab_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;

  // Smallest counter width able to hold the terminal count cycles-1.
  function automatic int cnt_width(input int cycles);
    int w;
    if (cycles <= 2) begin
      w = 1;
    end else begin
      w = $clog2(cycles);
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, persistence counter, registered
// debounced level and edge pulses. flip exposes the next-edge toggle decision.
module debounce_ch
  import gate_lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic idle,
  output logic flip
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d   = ~db_q;
      cnt_d  = '0;
      rise_d = ~db_q;
      fall_d = db_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign flip = rise_d | fall_d;
  assign idle = (cnt_q == '0) && (sync2_q == db_q);

endmodule

// File: rtl/gate_in_debounce.sv
// Dual-channel debouncer feeding a two-input lab gate, with per-channel edge
// pulses, a once-per-combination change strobe and a quiescence flag.
module gate_in_debounce
  import gate_lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic pair_chg,
  output logic stable
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $fatal(1, "gate_in_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if ((CNT_W < 1) || (CNT_W > 62) ||
      ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES - 1))) begin : g_bad_width
    $fatal(1, "gate_in_debounce: CNT_W too narrow for DEBOUNCE_CYCLES-1");
  end

  logic a_idle_s, b_idle_s;
  logic a_flip_s, b_flip_s;
  logic pair_chg_q;

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ch_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (a_raw),
    .db   (a_db),
    .rise (a_rise),
    .fall (a_fall),
    .idle (a_idle_s),
    .flip (a_flip_s)
  );

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ch_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (b_raw),
    .db   (b_db),
    .rise (b_rise),
    .fall (b_fall),
    .idle (b_idle_s),
    .flip (b_flip_s)
  );

  // Simultaneous flips on both channels collapse into a single strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_chg_q <= 1'b0;
    end else begin
      pair_chg_q <= a_flip_s | b_flip_s;
    end
  end

  assign pair_chg = pair_chg_q;
  assign stable   = a_idle_s & b_idle_s;

endmodule

// File: tb/tb_gate_in_debounce.sv
// Scoreboard bench for gate_in_debounce with DEBOUNCE_CYCLES=4.
module tb_gate_in_debounce;
  import gate_lab_pkg::*;

  // Raw change driven at a falling edge -> pulse seen at the falling edge
  // DEBOUNCE_CYCLES+2 rising edges later (2 sync edges + 4 count edges).
  localparam int LAT = 6;

  typedef struct {
    int   cyc;
    logic ar, af, br, bf, adb, bdb;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a_db, b_db, a_rise, a_fall, b_rise, b_fall, pair_chg, stable;
  logic gate_y;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pulse_cnt = 0;
  ev_t  exp_q[$];

  gate_in_debounce #(.DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES), .CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_raw   (a_raw),
    .b_raw   (b_raw),
    .a_db    (a_db),
    .b_db    (b_db),
    .a_rise  (a_rise),
    .a_fall  (a_fall),
    .b_rise  (b_rise),
    .b_fall  (b_fall),
    .pair_chg(pair_chg),
    .stable  (stable)
  );

  assign gate_y = a_db & b_db;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input logic ar, input logic af, input logic br,
                         input logic bf, input logic adb, input logic bdb);
    ev_t e;
    e.cyc = cyc + LAT;
    e.ar = ar; e.af = af; e.br = br; e.bf = bf; e.adb = adb; e.bdb = bdb;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse cycle must match the next expected event exactly.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (a_rise || a_fall || b_rise || b_fall || pair_chg)) begin
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got ar%0b af%0b br%0b bf%0b pc%0b at cyc %0d, expected none",
                 a_rise, a_fall, b_rise, b_fall, pair_chg, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((cyc != e.cyc) || (a_rise != e.ar) || (a_fall != e.af) ||
            (b_rise != e.br) || (b_fall != e.bf) || (pair_chg !== 1'b1) ||
            (a_db != e.adb) || (b_db != e.bdb)) begin
          errors++;
          $display("FAIL pulse_event: got cyc%0d ar%0b af%0b br%0b bf%0b pc%0b adb%0b bdb%0b expected cyc%0d ar%0b af%0b br%0b bf%0b pc1 adb%0b bdb%0b",
                   cyc, a_rise, a_fall, b_rise, b_fall, pair_chg, a_db, b_db,
                   e.cyc, e.ar, e.af, e.br, e.bf, e.adb, e.bdb);
        end
      end
    end
  end

  initial begin
    int pc_start;

    // Test 1: reset and idle
    tick(3);
    chk("reset_a_db", int'(a_db), 0);
    chk("reset_b_db", int'(b_db), 0);
    chk("reset_stable", int'(stable), 1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_stable_db", int'({stable, a_db, b_db}), 4);
    end

    // Test 2: A rises and is held
    a_raw = 1'b1;
    push_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(LAT - 1);
    chk("a_db_before_flip", int'(a_db), 0);
    tick(5);
    chk("a_db_after_flip", int'(a_db), 1);
    chk("b_db_untouched", int'(b_db), 0);

    // Test 3: B bounces 1,0,1,0 then settles high
    b_raw = 1'b1; tick(1);
    b_raw = 1'b0; tick(1);
    b_raw = 1'b1; tick(1);
    b_raw = 1'b0; tick(1);
    chk("b_db_during_bounce", int'(b_db), 0);
    b_raw = 1'b1;
    push_ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(12);
    chk("b_db_after_bounce", int'(b_db), 1);

    // Test 4: simultaneous fall, then simultaneous rise
    a_raw = 1'b0; b_raw = 1'b0;
    push_ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(10);
    a_raw = 1'b1; b_raw = 1'b1;
    push_ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(10);
    chk("both_high", int'({a_db, b_db}), 3);

    // Test 5: reset during an in-progress count
    a_raw = 1'b0; b_raw = 1'b0;
    tick(3);
    chk("stable_mid_count", int'(stable), 0);
    rst_n = 1'b0;
    #1;
    chk("async_clear_a_db", int'(a_db), 0);
    chk("async_clear_b_db", int'(b_db), 0);
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("post_reset_stable_db", int'({stable, a_db, b_db}), 4);
    end

    // Test 6: walk 00,01,10,11 into the AND gate
    pc_start = pulse_cnt;
    tick(10);
    chk("gate_00", int'(gate_y), 0);
    b_raw = 1'b1;
    push_ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(10);
    chk("gate_01", int'(gate_y), 0);
    a_raw = 1'b1; b_raw = 1'b0;
    push_ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(10);
    chk("gate_10", int'(gate_y), 0);
    b_raw = 1'b1;
    push_ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(10);
    chk("gate_11", int'(gate_y), 1);
    chk("walk_pair_chg_count", pulse_cnt - pc_start, 3);

    tick(4);
    chk("events_outstanding", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
